// File: rtl/serial_word_rx.sv
// serial_word_rx: framed LSB-first serial receiver with a one-deep
// valid/ready output register and parity, framing and overrun status.
module serial_word_rx #(
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  bit_en,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    logic [1:0]            sync_q;
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  par_q, par_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  oerr_q, oerr_d;
    logic                  s;
    logic                  frame_perr;
    logic                  commit;

    assign s          = sync_q[1];
    // Even parity: data bits XOR parity bit must be zero.
    assign frame_perr = PARITY_EN & ((^word_q) ^ par_q);

    // Two-flop synchronizer for the asynchronous serial line, idle high.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    // Frame state machine and output register next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = 1'b0;
        oerr_d  = 1'b0;
        commit  = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!s) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                S_DATA: begin
                    word_d[cnt_q] = s;
                    cnt_d         = cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    par_d   = s;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (s) begin
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (s) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A word may land in a register being emptied this same cycle.
        if (commit) begin
            if (!valid_q || rx_ready) begin
                data_d  = word_q;
                perr_d  = frame_perr;
                valid_d = 1'b1;
            end else begin
                oerr_d = 1'b1;
            end
        end
    end

    // State, shift register and output register updates.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// tb_serial_word_rx: directed and random frames against a
// cycle-level model of the output register and status pulses.
module tb_serial_word_rx;

    localparam int DW  = 8;
    localparam bit PEN = 1'b1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          serial_in = 1'b1;
    logic          bit_en = 1'b0;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ferr   = 0;
    int n_oerr   = 0;
    int n_acc    = 0;
    int rdy_mode = 0;

    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic          m_perr  = 1'b0;
    logic          m_ferr  = 1'b0;
    logic          m_oerr  = 1'b0;

    logic          ev_stop = 1'b0;
    logic          ev_good = 1'b0;
    logic [DW-1:0] ev_word = '0;
    logic          ev_perr = 1'b0;
    logic          rdy_on_stop = 1'b0;

    always #5 clock = ~clock;

    serial_word_rx #(
        .DATA_WIDTH(DW),
        .PARITY_EN (PEN)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .serial_in  (serial_in),
        .bit_en     (bit_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun_err(overrun_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        case (rdy_mode)
            0:       rx_ready = 1'b0;
            1:       rx_ready = 1'b1;
            default: rx_ready = ($urandom_range(0, 2) != 0);
        endcase
    endtask

    task automatic send_bit(input logic b, input bit is_stop, input int gap);
        serial_in = b;
        repeat (gap) tick();
        bit_en = 1'b1;
        if (is_stop) begin
            ev_stop = 1'b1;
            ev_good = b;
            if (rdy_on_stop) rx_ready = 1'b1;
        end
        tick();
        bit_en  = 1'b0;
        ev_stop = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pflip,
                              input logic stop_b, input int gap);
        logic pbit;
        pbit    = (^d) ^ pflip;
        ev_word = d;
        ev_perr = PEN ? ((^d) ^ pbit) : 1'b0;
        send_bit(1'b0, 1'b0, gap);
        for (int i = 0; i < DW; i++) send_bit(d[i], 1'b0, gap);
        if (PEN) send_bit(pbit, 1'b0, gap);
        send_bit(stop_b, 1'b1, gap);
    endtask

    // Compare outputs mid-cycle, then advance the model to the next edge.
    always @(negedge clock) begin
        logic commit_ok;
        logic acc;
        check_eq("rx_valid", rx_valid, m_valid);
        check_eq("rx_data", rx_data, m_data);
        if (m_valid) check_eq("parity_err", parity_err, m_perr);
        check_eq("frame_err", frame_err, m_ferr);
        check_eq("overrun_err", overrun_err, m_oerr);
        if (frame_err === 1'b1) n_ferr++;
        if (overrun_err === 1'b1) n_oerr++;
        if (rx_valid === 1'b1 && rx_ready) n_acc++;

        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_perr  = 1'b0;
            m_ferr  = 1'b0;
            m_oerr  = 1'b0;
        end else begin
            m_ferr    = bit_en && ev_stop && !ev_good;
            m_oerr    = 1'b0;
            commit_ok = bit_en && ev_stop && ev_good;
            acc       = m_valid && rx_ready;
            if (commit_ok && m_valid && !rx_ready) begin
                m_oerr = 1'b1;
            end else if (commit_ok) begin
                m_valid = 1'b1;
                m_data  = ev_word;
                m_perr  = ev_perr;
            end else if (acc) begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        int o0;
        int f0;
        int a0;
        repeat (3) tick();
        check_eq("rst_valid", rx_valid, 0);
        check_eq("rst_data", rx_data, 0);
        check_eq("rst_perr", parity_err, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_oerr", overrun_err, 0);
        reset = 1'b0;
        tick();

        rdy_mode = 1;
        a0 = n_acc;
        send_frame(8'hA5, 1'b0, 1'b1, 2);
        repeat (4) tick();
        check_eq("basic_acc", n_acc - a0, 1);

        rdy_mode = 0;
        send_frame(8'h3C, 1'b1, 1'b1, 3);
        tick();
        check_eq("perr_valid", rx_valid, 1);
        check_eq("perr_data", rx_data, 8'h3C);
        check_eq("perr_flag", parity_err, 1);
        rdy_mode = 1;
        repeat (3) tick();

        rdy_mode = 0;
        o0 = n_oerr;
        send_frame(8'h11, 1'b0, 1'b1, 2);
        send_frame(8'h22, 1'b0, 1'b1, 2);
        repeat (3) tick();
        check_eq("ovr_data", rx_data, 8'h11);
        check_eq("ovr_pulses", n_oerr - o0, 1);
        rdy_mode = 1;
        tick();
        tick();
        check_eq("ovr_drain", rx_valid, 0);

        rdy_mode = 0;
        o0 = n_oerr;
        send_frame(8'h11, 1'b0, 1'b1, 2);
        rdy_on_stop = 1'b1;
        send_frame(8'h22, 1'b0, 1'b1, 2);
        rdy_on_stop = 1'b0;
        tick();
        check_eq("sim_valid", rx_valid, 1);
        check_eq("sim_data", rx_data, 8'h22);
        check_eq("sim_noovr", n_oerr - o0, 0);
        rdy_mode = 1;
        repeat (3) tick();

        f0 = n_ferr;
        a0 = n_acc;
        send_frame(8'h55, 1'b0, 1'b0, 2);
        repeat (20) send_bit(1'b0, 1'b0, 2);
        send_bit(1'b1, 1'b0, 2);
        check_eq("brk_ferr", n_ferr - f0, 1);
        check_eq("brk_noword", n_acc - a0, 0);
        send_frame(8'h0F, 1'b0, 1'b1, 2);
        repeat (4) tick();
        check_eq("brk_next", n_acc - a0, 1);

        rdy_mode = 0;
        send_frame(8'h33, 1'b0, 1'b1, 2);
        send_bit(1'b0, 1'b0, 2);
        repeat (4) send_bit(1'b1, 1'b0, 2);
        reset = 1'b1;
        tick();
        tick();
        check_eq("mid_valid", rx_valid, 0);
        check_eq("mid_data", rx_data, 0);
        check_eq("mid_perr", parity_err, 0);
        check_eq("mid_ferr", frame_err, 0);
        check_eq("mid_oerr", overrun_err, 0);
        serial_in = 1'b1;
        reset = 1'b0;
        tick();
        a0 = n_acc;
        rdy_mode = 1;
        send_frame(8'h81, 1'b0, 1'b1, 2);
        repeat (4) tick();
        check_eq("mid_word", n_acc - a0, 1);

        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            logic [DW-1:0] d;
            logic          pf;
            logic          sb;
            int            g;
            d  = DW'($urandom);
            pf = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 7) != 0);
            g  = $urandom_range(2, 4);
            send_frame(d, pf, sb, g);
            if (!sb) begin
                repeat ($urandom_range(1, 2)) send_bit(1'b1, 1'b0, g);
            end else if ($urandom_range(0, 1) == 1) begin
                send_bit(1'b1, 1'b0, g);
            end
        end
        rdy_mode = 1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
